// File: rtl/matrix_stream_out_pkg.sv
// Shared definitions for the matrix stream reader: packed 2D bus macros,
// default geometry, index widths and state encoding.
`ifndef MATRIX_STREAM_OUT_PKG_SV
`define MATRIX_STREAM_OUT_PKG_SV

// Width of a packed H x W matrix bus of bl-bit elements.
`define PORT_2D(bl, h, w) ((bl) * (h) * (w))
// Slice of element (i,j), 1-based, inside a packed 2D bus.
`define UNPACK_2D(bus, bl, w, i, j) bus[(((i) - 1) * (w) + ((j) - 1)) * (bl) +: (bl)]

package matrix_stream_out_pkg;

    localparam int unsigned DEF_BITLENGTH = 8;
    localparam int unsigned DEF_H         = 3;
    localparam int unsigned DEF_W         = 4;

    localparam int unsigned ROW_W = $clog2(DEF_H + 1);
    localparam int unsigned COL_W = $clog2(DEF_W + 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    typedef enum logic {
        S_IDLE   = ST_IDLE,
        S_STREAM = ST_STREAM
    } state_e;

    // Width of a 1-based index that must hold values up to n.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

`endif

// File: rtl/matrix_index_counter.sv
// 1-based (row, col) walker over an H x W matrix with wrap and last flag.
// Traversal is column-major when MATRIX_STREAM_COL_MAJOR_EN is defined,
// row-major otherwise.
module matrix_index_counter
    import matrix_stream_out_pkg::*;
#(
    parameter  int unsigned H  = DEF_H,
    parameter  int unsigned W  = DEF_W,
    localparam int unsigned RW = idx_w(H),
    localparam int unsigned CW = idx_w(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [RW-1:0] ROW_MAX = RW'(H);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [CW-1:0] COL_MAX = CW'(W);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_q, last_d;

    // Next index: clear restarts at (1,1); advance steps with wrap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = ROW_ONE;
            col_d = COL_ONE;
        end else if (advance) begin
`ifdef MATRIX_STREAM_COL_MAJOR_EN
            if (row_q == ROW_MAX) begin
                row_d = ROW_ONE;
                col_d = (col_q == COL_MAX) ? COL_ONE : col_q + COL_ONE;
            end else begin
                row_d = row_q + ROW_ONE;
            end
`else
            if (col_q == COL_MAX) begin
                col_d = COL_ONE;
                row_d = (row_q == ROW_MAX) ? ROW_ONE : row_q + ROW_ONE;
            end else begin
                col_d = col_q + COL_ONE;
            end
`endif
        end
        last_d = (row_d == ROW_MAX) && (col_d == COL_MAX);
    end

    // Index registers; last is registered alongside so it never lags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q  <= ROW_ONE;
            col_q  <= COL_ONE;
            last_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            last_q <= last_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = last_q;

endmodule

// File: rtl/matrix_stream_out.sv
// Captures a packed H x W matrix (valid/ready) and serialises it one element
// per beat (valid/ready). Define MATRIX_STREAM_COL_MAJOR_EN for column-major
// order; default is row-major.
module matrix_stream_out
    import matrix_stream_out_pkg::*;
#(
    parameter  int unsigned bitlength = DEF_BITLENGTH,
    parameter  int unsigned H         = DEF_H,
    parameter  int unsigned W         = DEF_W,
    localparam int unsigned MAT_W     = `PORT_2D(bitlength, H, W),
    localparam int unsigned RW        = idx_w(H),
    localparam int unsigned CW        = idx_w(W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MAT_W-1:0]     mat_i,
    input  logic                 mat_valid_i,
    output logic                 mat_ready_o,
    output logic [bitlength-1:0] elem_o,
    output logic                 elem_valid_o,
    input  logic                 elem_ready_i,
    output logic [RW-1:0]        row_o,
    output logic [CW-1:0]        col_o,
    output logic                 last_o
);

    state_e          state_q, state_d;
    logic [MAT_W-1:0] hold_q, hold_d;
    logic [MAT_W-1:0] ordered_c;
    logic             clear_c;
    logic             advance_c;
    logic             mat_ready_c;
    logic             last_c;

    matrix_index_counter #(
        .H(H),
        .W(W)
    ) u_index (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .advance(advance_c),
        .row    (row_o),
        .col    (col_o),
        .last   (last_c)
    );

    // Reorder the incoming matrix into traversal order so the holding
    // register can simply shift one element out per accepted beat.
    always_comb begin
        ordered_c = mat_i;
`ifdef MATRIX_STREAM_COL_MAJOR_EN
        for (int unsigned i = 1; i <= H; i++) begin
            for (int unsigned j = 1; j <= W; j++) begin
                ordered_c[((j - 1) * H + (i - 1)) * bitlength +: bitlength] =
                    `UNPACK_2D(mat_i, bitlength, W, i, j);
            end
        end
`endif
    end

    // Next-state, capture/shift control and matrix-side ready.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        clear_c     = 1'b0;
        advance_c   = 1'b0;
        mat_ready_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                mat_ready_c = 1'b1;
                if (mat_valid_i) begin
                    hold_d  = ordered_c;
                    clear_c = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                mat_ready_c = last_c && elem_ready_i;
                if (elem_ready_i) begin
                    advance_c = 1'b1;
                    hold_d    = hold_q >> bitlength;
                    if (last_c) begin
                        if (mat_valid_i) begin
                            hold_d  = ordered_c;
                            clear_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // State and holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign mat_ready_o  = mat_ready_c;
    assign elem_o       = hold_q[bitlength-1:0];
    assign elem_valid_o = (state_q == S_STREAM);
    assign last_o       = last_c;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Self-checking bench for matrix_stream_out (3x4 instance plus a 1x1 instance).
module tb_matrix_stream_out;

    localparam int unsigned BL = 8;
    localparam int unsigned H  = 3;
    localparam int unsigned W  = 4;
    localparam int unsigned MW = BL * H * W;
    localparam int unsigned RW = $clog2(H + 1);
    localparam int unsigned CW = $clog2(W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [MW-1:0] mat_i;
    logic          mat_valid_i;
    logic          mat_ready_o;
    logic [BL-1:0] elem_o;
    logic          elem_valid_o;
    logic          elem_ready_i;
    logic [RW-1:0] row_o;
    logic [CW-1:0] col_o;
    logic          last_o;

    logic [BL-1:0] d_mat_i;
    logic          d_mat_valid_i;
    logic          d_mat_ready_o;
    logic [BL-1:0] d_elem_o;
    logic          d_elem_valid_o;
    logic          d_elem_ready_i;
    logic [0:0]    d_row_o;
    logic [0:0]    d_col_o;
    logic          d_last_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [BL-1:0] e;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [MW-1:0] pend_q[$];

    matrix_stream_out #(.bitlength(BL), .H(H), .W(W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mat_i       (mat_i),
        .mat_valid_i (mat_valid_i),
        .mat_ready_o (mat_ready_o),
        .elem_o      (elem_o),
        .elem_valid_o(elem_valid_o),
        .elem_ready_i(elem_ready_i),
        .row_o       (row_o),
        .col_o       (col_o),
        .last_o      (last_o)
    );

    matrix_stream_out #(.bitlength(BL), .H(1), .W(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .mat_i       (d_mat_i),
        .mat_valid_i (d_mat_valid_i),
        .mat_ready_o (d_mat_ready_o),
        .elem_o      (d_elem_o),
        .elem_valid_o(d_elem_valid_o),
        .elem_ready_i(d_elem_ready_i),
        .row_o       (d_row_o),
        .col_o       (d_col_o),
        .last_o      (d_last_o)
    );

    // Element (i,j), 1-based, of a packed matrix.
    function automatic logic [BL-1:0] elem_at(input logic [MW-1:0] m, input int i, input int j);
        return m[((i - 1) * W + (j - 1)) * BL +: BL];
    endfunction

    function automatic logic [MW-1:0] pat_matrix();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 1; i <= H; i++)
            for (int j = 1; j <= W; j++)
                m[((i - 1) * W + (j - 1)) * BL +: BL] = BL'(10 * i + j);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_matrix();
        logic [MW-1:0] m;
        for (int k = 0; k < H * W; k++) m[k * BL +: BL] = BL'($urandom);
        return m;
    endfunction

    // Reference: the beats a matrix must produce, in traversal order.
    task automatic push_beats(input logic [MW-1:0] m);
        beat_t b;
`ifdef MATRIX_STREAM_COL_MAJOR_EN
        for (int j = 1; j <= W; j++) for (int i = 1; i <= H; i++) begin
`else
        for (int i = 1; i <= H; i++) for (int j = 1; j <= W; j++) begin
`endif
            b.e = elem_at(m, i, j);
            b.r = RW'(i);
            b.c = CW'(j);
            b.l = (i == H) && (j == W);
            exp_q.push_back(b);
        end
    endtask

    // Drives every matrix in pend_q and checks each cycle against exp_q.
    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_stream(input string name, input int ready_mode, input int gap_pct,
                              output int beats);
        int cyc = 0;
        int ph  = 0;
        bit acc = 1'b0;
        beats = 0;
        mat_valid_i = 1'b0;
        while (pend_q.size() != 0 || exp_q.size() != 0) begin
            if (cyc >= 2000) begin
                checks++; errors++;
                $display("FAIL %s timeout: %0d beats left", name, exp_q.size());
                break;
            end
            cyc++;
            @(posedge clk); #1;
            if (acc) mat_valid_i = 1'b0;
            acc = 1'b0;
            case (ready_mode)
                0:       elem_ready_i = 1'b1;
                1:       elem_ready_i = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: elem_ready_i = 1'($urandom_range(0, 1));
            endcase
            ph++;
            if (!mat_valid_i && pend_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
                mat_valid_i = 1'b1;
                mat_i       = pend_q[0];
            end
            #1;
            checks++;
            if (elem_valid_o !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL %s valid: got %b want %b", name, elem_valid_o, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({elem_o, row_o, col_o, last_o} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s beat: got elem=%h row=%0d col=%0d last=%b want elem=%h row=%0d col=%0d last=%b",
                             name, elem_o, row_o, col_o, last_o,
                             exp_q[0].e, exp_q[0].r, exp_q[0].c, exp_q[0].l);
                end
                checks++;
                if (mat_ready_o !== (exp_q[0].l && elem_ready_i)) begin
                    errors++;
                    $display("FAIL %s mat_ready streaming: got %b want %b", name, mat_ready_o,
                             exp_q[0].l && elem_ready_i);
                end
            end else begin
                checks++;
                if (mat_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s mat_ready idle: got %b want 1", name, mat_ready_o);
                end
            end
            if (elem_valid_o && elem_ready_i && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                beats++;
            end
            if (mat_valid_i && mat_ready_o) begin
                push_beats(pend_q.pop_front());
                acc = 1'b1;
            end
        end
        @(posedge clk); #1;
        mat_valid_i = 1'b0;
        #1;
        checks++;
        if (elem_valid_o !== 1'b0 || mat_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s end idle: got valid=%b ready=%b want 0 1", name, elem_valid_o, mat_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({mat_ready_o, elem_valid_o, last_o, row_o, col_o, elem_o} !==
            {1'b1, 1'b0, 1'b0, RW'(1), CW'(1), BL'(0)}) begin
            errors++;
            $display("FAIL reset state: got ready=%b valid=%b last=%b row=%0d col=%0d elem=%h",
                     mat_ready_o, elem_valid_o, last_o, row_o, col_o, elem_o);
        end
        // Abandon a matrix mid-stream.
        @(posedge clk); #1;
        mat_i = pat_matrix(); mat_valid_i = 1'b1; elem_ready_i = 1'b1;
        @(posedge clk); #1;
        mat_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (elem_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset prestream valid: got %b want 1", elem_valid_o);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({elem_valid_o, mat_ready_o, row_o, col_o} !== {1'b0, 1'b1, RW'(1), CW'(1)}) begin
            errors++;
            $display("FAIL reset midstream: got valid=%b ready=%b row=%0d col=%0d want 0 1 1 1",
                     elem_valid_o, mat_ready_o, row_o, col_o);
        end
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #2;
            checks++;
            if (elem_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset leftover beat: got valid=%b elem=%h want no beat", elem_valid_o, elem_o);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        pend_q.push_back(pat_matrix());
        run_stream("basic", 0, 0, n);
        checks++;
        if (n != 12) begin errors++; $display("FAIL basic count: got %0d want 12", n); end
    endtask

    task automatic test_backpressure();
        int n;
        pend_q.push_back(rand_matrix());
        run_stream("backpressure", 1, 0, n);
        checks++;
        if (n != 12) begin errors++; $display("FAIL backpressure count: got %0d want 12", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        pend_q.push_back(pat_matrix());
        pend_q.push_back({MW{1'b1}});
        run_stream("back_to_back", 0, 0, n);
        checks++;
        if (n != 24) begin errors++; $display("FAIL back_to_back count: got %0d want 24", n); end
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 4; k++) pend_q.push_back(rand_matrix());
        run_stream("random", 2, 30, n);
        checks++;
        if (n != 48) begin errors++; $display("FAIL random count: got %0d want 48", n); end
    endtask

    // 1x1 instance: three back-to-back single-beat matrices.
    task automatic test_degenerate();
        logic [BL-1:0] vals [3];
        int sent = 0;
        int got  = 0;
        vals = '{8'h05, 8'h06, 8'h07};
        d_elem_ready_i = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            d_mat_valid_i = (sent < 3);
            if (sent < 3) d_mat_i = vals[sent];
            #1;
            checks++;
            if (d_elem_valid_o !== (cyc >= 1 && cyc <= 3)) begin
                errors++;
                $display("FAIL degenerate valid cycle %0d: got %b want %b", cyc, d_elem_valid_o,
                         cyc >= 1 && cyc <= 3);
            end
            if (d_elem_valid_o && got < 3) begin
                checks++;
                if ({d_elem_o, d_row_o, d_col_o, d_last_o} !== {vals[got], 1'b1, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL degenerate beat %0d: got elem=%h row=%0d col=%0d last=%b want %h 1 1 1",
                             got, d_elem_o, d_row_o, d_col_o, d_last_o, vals[got]);
                end
                got++;
            end
            if (d_mat_valid_i && d_mat_ready_o) sent++;
        end
        d_mat_valid_i = 1'b0;
        checks++;
        if (got != 3) begin errors++; $display("FAIL degenerate count: got %0d want 3", got); end
    endtask

    initial begin
        rst_n          = 1'b0;
        mat_i          = '0;
        mat_valid_i    = 1'b0;
        elem_ready_i   = 1'b0;
        d_mat_i        = '0;
        d_mat_valid_i  = 1'b0;
        d_elem_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
